// File: rtl/level_sweep_seq.sv
// level_sweep_seq: steps a DAC threshold per delay code until the comparator drops, reporting one crossing point per delay code.
// Define LEVEL_SWEEP_TIMEOUT_EN to add a strobe watchdog that drives err_o.
module level_sweep_seq #(
    parameter int DAC_CODE_WIDTH   = 16,
    parameter int DELAY_CODE_WIDTH = 10,
    parameter int SETTLE_STB       = 3,
    parameter int TIMEOUT_CYCLES   = 2**24
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        run_i,
    input  logic                        abort_i,
    input  logic                        stb_i,
    input  logic                        cmp_out_i,
    input  logic [DAC_CODE_WIDTH-1:0]   threshold_start_i,
    input  logic [DAC_CODE_WIDTH-1:0]   threshold_delta_i,
    input  logic [DELAY_CODE_WIDTH-1:0] d_code_delta_i,
    output logic [DAC_CODE_WIDTH-1:0]   threshold_o,
    output logic                        threshold_wre_o,
    input  logic                        threshold_rdy_i,
    output logic [DELAY_CODE_WIDTH-1:0] d_code_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        point_rdy_o,
    output logic [DAC_CODE_WIDTH-1:0]   point_v_o,
    output logic [DELAY_CODE_WIDTH-1:0] point_t_o,
    output logic                        point_ovf_o
);
    localparam int SW = $clog2(SETTLE_STB + 2);
    typedef enum logic [2:0] {IDLE, DAC_WR, DAC_WAIT, SETTLE, SAMPLE, POINT, NEXT_T} state_t;
    state_t state;
    logic [DAC_CODE_WIDTH-1:0] start;
    logic [DAC_CODE_WIDTH-1:0] tdelta;
    logic [DELAY_CODE_WIDTH-1:0] ddelta;
    logic [SW-1:0] stb_cnt;
    logic [DAC_CODE_WIDTH:0] tsum;
    logic [DELAY_CODE_WIDTH:0] dsum;
    logic timeout;
    // the extra top bit of each sum flags a step past the code range
    assign tsum = {1'b0, threshold_o} + {1'b0, tdelta};
    assign dsum = {1'b0, d_code_o} + {1'b0, ddelta};
`ifdef LEVEL_SWEEP_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic waiting;
    assign waiting = (state == SETTLE) || (state == SAMPLE);
    assign timeout = waiting && !stb_i && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_i) begin
        if (rst_i || !waiting || stb_i) wd_cnt <= '0;
        else wd_cnt <= wd_cnt + 1'b1;
        if (rst_i) err_o <= 1'b0;
        else if (state == IDLE && run_i && !abort_i) err_o <= 1'b0;
        else if (timeout) err_o <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err_o = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        threshold_wre_o <= 1'b0;
        done_o <= 1'b0;
        point_rdy_o <= 1'b0;
        if (rst_i) begin
            state <= IDLE;
            threshold_o <= '0;
            d_code_o <= '0;
            busy_o <= 1'b0;
            point_v_o <= '0;
            point_t_o <= '0;
            point_ovf_o <= 1'b0;
            start <= '0;
            tdelta <= '0;
            ddelta <= '0;
            stb_cnt <= '0;
        end else if (abort_i || timeout) begin
            state <= IDLE;
            busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (run_i) begin
                    start <= threshold_start_i;
                    tdelta <= (threshold_delta_i == '0) ? DAC_CODE_WIDTH'(1) : threshold_delta_i;
                    ddelta <= (d_code_delta_i == '0) ? DELAY_CODE_WIDTH'(1) : d_code_delta_i;
                    threshold_o <= threshold_start_i;
                    d_code_o <= '0;
                    busy_o <= 1'b1;
                    state <= DAC_WR;
                end
                DAC_WR: if (threshold_rdy_i) begin
                    threshold_wre_o <= 1'b1;
                    state <= DAC_WAIT;
                end
                // the write pulse marks the first DAC_WAIT cycle, when rdy may not yet have dropped
                DAC_WAIT: if (!threshold_wre_o && threshold_rdy_i) begin
                    stb_cnt <= '0;
                    state <= SETTLE;
                end
                SETTLE: if (SETTLE_STB == 0) state <= SAMPLE;
                else if (stb_i) begin
                    stb_cnt <= stb_cnt + 1'b1;
                    if (stb_cnt == SW'(SETTLE_STB - 1)) state <= SAMPLE;
                end
                SAMPLE: if (stb_i) begin
                    if (cmp_out_i && !tsum[DAC_CODE_WIDTH]) begin
                        threshold_o <= tsum[DAC_CODE_WIDTH-1:0];
                        state <= DAC_WR;
                    end else begin
                        point_v_o <= cmp_out_i ? '1 : threshold_o;
                        point_ovf_o <= cmp_out_i;
                        point_t_o <= d_code_o;
                        point_rdy_o <= 1'b1;
                        state <= POINT;
                    end
                end
                POINT: state <= NEXT_T;
                NEXT_T: if (dsum[DELAY_CODE_WIDTH]) begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state <= IDLE;
                end else begin
                    d_code_o <= dsum[DELAY_CODE_WIDTH-1:0];
                    threshold_o <= start;
                    state <= DAC_WR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_level_sweep_seq.sv
// tb_level_sweep_seq: directed sweeps; expected points and done events are queued and a monitor compares them as the DUT emits them.
module tb_level_sweep_seq;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic run_i = 1'b0;
    logic abort_i = 1'b0;
    logic stb_i = 1'b0;
    logic cmp_out_i;
    logic threshold_rdy_i = 1'b1;
    logic [15:0] threshold_start_i = '0;
    logic [15:0] threshold_delta_i = '0;
    logic [9:0] d_code_delta_i = '0;
    logic [15:0] threshold_o;
    logic [15:0] point_v_o;
    logic [9:0] d_code_o;
    logic [9:0] point_t_o;
    logic threshold_wre_o, busy_o, done_o, err_o, point_rdy_o, point_ovf_o;
    int cmp_limit = 0;
    int checks = 0;
    int errors = 0;
    int wre_cnt = 0;
    int done_seen = 0;
    int stb_req = 0;
    int w0 = 0;
    bit stb_auto = 1'b1;
    typedef struct packed {
        logic done;
        logic [15:0] v;
        logic [9:0] t;
        logic ovf;
    } ev_t;
    ev_t exp_q[$];

    // comparator model: output high while the DAC threshold is below the signal level
    assign cmp_out_i = int'(threshold_o) < cmp_limit;
    always #5 clk = ~clk;

    level_sweep_seq #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .abort_i(abort_i), .stb_i(stb_i),
        .cmp_out_i(cmp_out_i), .threshold_start_i(threshold_start_i),
        .threshold_delta_i(threshold_delta_i), .d_code_delta_i(d_code_delta_i),
        .threshold_o(threshold_o), .threshold_wre_o(threshold_wre_o),
        .threshold_rdy_i(threshold_rdy_i), .d_code_o(d_code_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .point_rdy_o(point_rdy_o), .point_v_o(point_v_o),
        .point_t_o(point_t_o), .point_ovf_o(point_ovf_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        ev_t e;
        logic wre_prev;
        wre_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (threshold_wre_o) begin
                wre_cnt++;
                check("wre_single_cycle", 32'(wre_prev), 32'd0);
            end
            wre_prev = threshold_wre_o;
            if (done_o) done_seen++;
            if (point_rdy_o || done_o) begin
                if (exp_q.size() == 0) check("unexpected_event", 32'({point_rdy_o, done_o}), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'({point_rdy_o, done_o}), e.done ? 32'd1 : 32'd2);
                    if (!e.done) begin
                        check("point_v", 32'(point_v_o), 32'(e.v));
                        check("point_t", 32'(point_t_o), 32'(e.t));
                        check("point_ovf", 32'(point_ovf_o), 32'(e.ovf));
                    end
                end
            end
        end
    endtask

    task automatic strobe_gen();
        int fired;
        fired = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stb_auto) stb_i = !stb_i;
            else if (!stb_i && fired < stb_req) begin
                stb_i = 1'b1;
                fired++;
            end else stb_i = 1'b0;
        end
    endtask

    task automatic expect_point(input logic [15:0] v, input logic [9:0] t, input logic ovf);
        exp_q.push_back('{1'b0, v, t, ovf});
    endtask

    task automatic expect_done();
        exp_q.push_back('{1'b1, 16'h0, 10'h0, 1'b0});
    endtask

    task automatic start_sweep(input logic [15:0] s, input logic [15:0] td, input logic [9:0] dd, input int lim);
        threshold_start_i = s;
        threshold_delta_i = td;
        d_code_delta_i = dd;
        cmp_limit = lim;
        run_i = 1'b1;
        tick(1);
        run_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int target;
        target = done_seen + 1;
        for (int i = 0; i < budget && done_seen < target; i++) begin
            @(negedge clk);
            #2;
        end
        check({name, "_done_seen"}, 32'(done_seen >= target), 32'd1);
    endtask

    task automatic wait_wre(input string name, input int target, input int budget);
        for (int i = 0; i < budget && wre_cnt < target; i++) begin
            @(negedge clk);
            #2;
        end
        check({name, "_wre_seen"}, 32'(wre_cnt >= target), 32'd1);
    endtask

    initial begin
        fork
            monitor();
            strobe_gen();
        join_none
        tick(3);
        check("rst_threshold", 32'(threshold_o), 32'd0);
        check("rst_dcode", 32'(d_code_o), 32'd0);
        check("rst_wre", 32'(threshold_wre_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_point_rdy", 32'(point_rdy_o), 32'd0);
        check("rst_point_v", 32'(point_v_o), 32'd0);
        check("rst_point_t", 32'(point_t_o), 32'd0);
        check("rst_point_ovf", 32'(point_ovf_o), 32'd0);
        rst_i = 1'b0;
        tick(2);
        // basic sweep; inputs scrambled and run re-pulsed mid-sweep must not disturb it
        w0 = wre_cnt;
        expect_point(16'd130, 10'd0, 1'b0);
        expect_point(16'd130, 10'd512, 1'b0);
        expect_done();
        start_sweep(16'd100, 16'd10, 10'd512, 130);
        check("run_busy", 32'(busy_o), 32'd1);
        check("run_threshold", 32'(threshold_o), 32'd100);
        check("run_dcode", 32'(d_code_o), 32'd0);
        threshold_start_i = 16'h1234;
        threshold_delta_i = 16'd7;
        d_code_delta_i = 10'd3;
        tick(5);
        run_i = 1'b1;
        tick(1);
        run_i = 1'b0;
        wait_done("basic", 3000);
        check("basic_dac_writes", 32'(wre_cnt - w0), 32'd8);
        tick(1);
        check("basic_idle_busy", 32'(busy_o), 32'd0);
        // DAC not ready: no write until rdy rises
        threshold_rdy_i = 1'b0;
        w0 = wre_cnt;
        expect_point(16'd0, 10'd0, 1'b0);
        expect_point(16'd0, 10'd1023, 1'b0);
        expect_done();
        start_sweep(16'd0, 16'd1, 10'd1023, 0);
        tick(20);
        check("rdy_low_no_write", 32'(wre_cnt - w0), 32'd0);
        threshold_rdy_i = 1'b1;
        tick(3);
        check("rdy_high_one_write", 32'(wre_cnt - w0), 32'd1);
        wait_done("rdy_hold", 3000);
        // threshold overflow saturates instead of wrapping
        expect_point(16'hFFFF, 10'd0, 1'b1);
        expect_point(16'hFFFF, 10'd1023, 1'b1);
        expect_done();
        start_sweep(16'hFFF0, 16'd16, 10'd1023, 70000);
        wait_done("ovf", 3000);
        check("ovf_threshold_no_wrap", 32'(threshold_o), 32'hFFF0);
        // zero deltas act as 1: every delay code 0..1023 produces a point
        for (int i = 0; i < 1024; i++) expect_point(16'd1, 10'(i), 1'b0);
        expect_done();
        start_sweep(16'd0, 16'd0, 10'd0, 1);
        wait_done("zero_delta", 60000);
        // abort during SETTLE of the second delay code, after two strobes
        w0 = wre_cnt;
        expect_point(16'd100, 10'd0, 1'b0);
        start_sweep(16'd100, 16'd10, 10'd512, 100);
        wait_wre("abort", w0 + 2, 200);
        stb_auto = 1'b0;
        tick(3);
        check("abort_pre_dcode", 32'(d_code_o), 32'd512);
        stb_req += 2;
        tick(6);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        stb_auto = 1'b1;
        tick(40);
        check("abort_no_more_writes", 32'(wre_cnt - w0), 32'd2);
        expect_point(16'd100, 10'd0, 1'b0);
        expect_point(16'd100, 10'd512, 1'b0);
        expect_done();
        start_sweep(16'd100, 16'd10, 10'd512, 100);
        check("restart_dcode", 32'(d_code_o), 32'd0);
        wait_done("restart", 3000);
        // reset mid-sweep
        w0 = wre_cnt;
        start_sweep(16'd100, 16'd10, 10'd512, 130);
        wait_wre("rst_mid", w0 + 2, 200);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_threshold", 32'(threshold_o), 32'd0);
        check("rst_mid_point_v", 32'(point_v_o), 32'd0);
        tick(40);
        check("rst_mid_no_writes", 32'(wre_cnt - w0), 32'd2);
        // strobes stop while waiting in SAMPLE
        stb_auto = 1'b0;
        w0 = wre_cnt;
        start_sweep(16'd100, 16'd10, 10'd512, 130);
        wait_wre("wd", w0 + 1, 50);
        tick(3);
        stb_req += 3;
        tick(8);
        tick(50);
        check("wd_early_err", 32'(err_o), 32'd0);
        check("wd_early_busy", 32'(busy_o), 32'd1);
`ifdef LEVEL_SWEEP_TIMEOUT_EN
        for (int i = 0; i < 100 && !err_o; i++) tick(1);
        check("wd_err", 32'(err_o), 32'd1);
        check("wd_busy", 32'(busy_o), 32'd0);
        start_sweep(16'd100, 16'd10, 10'd512, 130);
        check("wd_err_cleared", 32'(err_o), 32'd0);
`else
        tick(150);
        check("no_wd_err", 32'(err_o), 32'd0);
        check("no_wd_busy", 32'(busy_o), 32'd1);
`endif
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        tick(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
